// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Purpose:
//   Fetches 16-bit instruction halfwords from a request/acknowledge memory
//   port and presents them to the decoder. There is one outstanding request
//   at most. The block supports redirects (branch, SWI, BIOS exit), HLT and
//   resume, and discards stale responses after a redirect.
//
// Parameters:
//   ADDR_WIDTH  width of the halfword-addressed PC and memory address
//   RESET_PC    first fetch address after reset
//   OS_START    first address outside BIOS space
//
// Ports:
//   clock        in   sole clock, rising edge
//   reset        in   synchronous, active-high
//   mem_req      out  fetch request (held with mem_addr until mem_ack)
//   mem_addr     out  fetch address
//   mem_ack      in   read data valid this cycle
//   mem_rdata    in   instruction halfword
//   redirect     in   branch taken / SWI / BIOS exit
//   redirect_pc  in   redirect target
//   halt         in   HLT retired (acts together with instr_ready)
//   resume       in   leave HALTED
//   instr_ready  in   decoder/control consumes Instruction
//   Instruction  out  instruction register feeding the decoder
//   instr_valid  out  Instruction holds a fetched word
//   pc           out  address of Instruction
//   is_bios      out  pc < OS_START
//   fetch_count  out  delivered-instruction counter
//
// Build option:
//   IF_PERF_COUNT_EN  when defined, fetch_count counts HOLD-state
//                     instr_ready handshakes (wrapping at 16 bits). When it
//                     is undefined, fetch_count is tied to 0 and no counter
//                     is built.
// ---------------------------------------------------------------------------
module instruction_fetch #(
   parameter int unsigned           ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter int unsigned           OS_START   = 2048
) (
   input  logic                  clock,
   input  logic                  reset,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_ack,
   input  logic [15:0]           mem_rdata,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   input  logic                  halt,
   input  logic                  resume,
   input  logic                  instr_ready,
   output logic [15:0]           Instruction,
   output logic                  instr_valid,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  is_bios,
   output logic [15:0]           fetch_count
);

   localparam logic [ADDR_WIDTH-1:0] OS_START_A = ADDR_WIDTH'(OS_START);

   typedef enum logic [1:0] {FETCH, HOLD, DRAIN, HALTED} state_t;

   state_t                state, state_next;
   logic [ADDR_WIDTH-1:0] pc_next;
   logic [15:0]           instr_next;
   logic                  valid_next;
   logic                  ack_block;
   logic                  ack_ok;

   // A response arriving in the first cycle after reset belongs to a request
   // that reset abandoned, so it is ignored.
   assign ack_ok   = mem_ack && !ack_block;

   assign mem_req  = (state == FETCH) && !reset;
   assign mem_addr = pc;
   assign is_bios  = (pc < OS_START_A);

   always_ff @(posedge clock) begin
      ack_block <= reset;
      if (reset) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         Instruction <= 16'hFFFF;
         instr_valid <= 1'b0;
      end else begin
         state       <= state_next;
         pc          <= pc_next;
         Instruction <= instr_next;
         instr_valid <= valid_next;
      end
   end

   // Priority inside every state: redirect > halt > instr_ready > mem_ack.
   always_comb begin
      state_next = state;
      pc_next    = pc;
      instr_next = Instruction;
      valid_next = instr_valid;
      case (state)
         FETCH: begin
            if (redirect) begin
               pc_next = redirect_pc;
               // Response in the same cycle closes the old request; otherwise
               // it is still in flight and must be drained.
               state_next = ack_ok ? FETCH : DRAIN;
            end else if (ack_ok) begin
               instr_next = mem_rdata;
               valid_next = 1'b1;
               state_next = HOLD;
            end
         end
         HOLD: begin
            if (redirect) begin
               pc_next    = redirect_pc;
               valid_next = 1'b0;
               state_next = FETCH;
            end else if (instr_ready) begin
               pc_next    = pc + ADDR_WIDTH'(1);
               valid_next = 1'b0;
               state_next = halt ? HALTED : FETCH;
            end
         end
         DRAIN: begin
            if (redirect) pc_next = redirect_pc;
            if (ack_ok) state_next = FETCH;
         end
         HALTED: begin
            if (redirect) begin
               pc_next    = redirect_pc;
               valid_next = 1'b0;
               state_next = FETCH;
            end else if (resume) begin
               state_next = FETCH;
            end
         end
         default: state_next = FETCH;
      endcase
   end

`ifdef IF_PERF_COUNT_EN
   logic        handshake;
   logic [15:0] count;

   assign handshake   = (state == HOLD) && instr_ready && !redirect;
   assign fetch_count = count;

   always_ff @(posedge clock) begin
      if (reset)          count <= '0;
      else if (handshake) count <= count + 16'd1;
   end
`else
   assign fetch_count = 16'd0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
//
// Directed bench for instruction_fetch with default parameters
// (ADDR_WIDTH 16, RESET_PC 0, OS_START 2048). Inputs change 1 time unit
// after the rising edge and outputs are sampled there as well.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

   logic        clock = 1'b0;
   logic        reset;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        halt;
   logic        resume;
   logic        instr_ready;
   logic [15:0] Instruction;
   logic        instr_valid;
   logic [15:0] pc;
   logic        is_bios;
   logic [15:0] fetch_count;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef IF_PERF_COUNT_EN
   localparam int PERF = 1;
`else
   localparam int PERF = 0;
`endif

   always #5 clock = ~clock;

   instruction_fetch dut (
      .clock       (clock),
      .reset       (reset),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halt        (halt),
      .resume      (resume),
      .instr_ready (instr_ready),
      .Instruction (Instruction),
      .instr_valid (instr_valid),
      .pc          (pc),
      .is_bios     (is_bios),
      .fetch_count (fetch_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1; mem_ack = 1'b0; mem_rdata = 16'h0; redirect = 1'b0;
      redirect_pc = 16'h0; halt = 1'b0; resume = 1'b0; instr_ready = 1'b0;
      tick(); tick();

      // reset state
      check("rst_mem_req", mem_req, 0);
      check("rst_valid", instr_valid, 0);
      check("rst_instr", Instruction, 16'hFFFF);
      check("rst_pc", pc, 0);
      check("rst_count", fetch_count, 0);
      check("rst_bios", is_bios, 1);

      // release reset with a stale ack present; it must be ignored
      reset = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hDEAD;
      #1;
      check("post_rst_req", mem_req, 1);
      check("post_rst_addr", mem_addr, 0);
      tick();
      mem_ack = 1'b0;
      check("stale_ack_ignored", instr_valid, 0);
      check("req_held", mem_req, 1);
      check("addr_held", mem_addr, 0);

      // memory acks two cycles after the request, decoder ready
      tick();
      mem_ack = 1'b1; mem_rdata = 16'h1234; instr_ready = 1'b1;
      tick();
      mem_ack = 1'b0;
      check("f0_valid", instr_valid, 1);
      check("f0_instr", Instruction, 16'h1234);
      check("f0_pc", pc, 0);
      check("f0_req_low", mem_req, 0);
      tick();
      instr_ready = 1'b0;
      check("f1_req", mem_req, 1);
      check("f1_addr", mem_addr, 1);
      check("f1_valid", instr_valid, 0);

      // HOLD with decoder stalled for five cycles
      mem_ack = 1'b1; mem_rdata = 16'h5A5A;
      tick();
      mem_ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("stall_instr", Instruction, 16'h5A5A);
         check("stall_pc", pc, 1);
         check("stall_req", mem_req, 0);
         check("stall_valid", instr_valid, 1);
         tick();
      end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      check("stall_next_addr", mem_addr, 2);
      check("stall_next_req", mem_req, 1);

      // redirect while a request is pending -> DRAIN, stale data dropped
      redirect = 1'b1; redirect_pc = 16'h0800;
      tick();
      redirect = 1'b0;
      check("drain_req", mem_req, 0);
      check("drain_pc", pc, 16'h0800);
      check("drain_bios", is_bios, 0);
      mem_ack = 1'b1; mem_rdata = 16'hDEAD;
      tick();
      mem_ack = 1'b0;
      check("drain_valid", instr_valid, 0);
      check("drain_instr_kept", Instruction, 16'h5A5A);
      check("drain_refetch_req", mem_req, 1);
      check("drain_refetch_addr", mem_addr, 16'h0800);
      mem_ack = 1'b1; mem_rdata = 16'hABCD;
      tick();
      mem_ack = 1'b0;
      check("os_instr", Instruction, 16'hABCD);
      check("os_pc", pc, 16'h0800);
      check("os_valid", instr_valid, 1);
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      check("os_next_addr", mem_addr, 16'h0801);
      check("count_three", fetch_count, PERF ? 3 : 0);

      // redirect coincident with mem_ack -> data dropped, stays in FETCH
      redirect = 1'b1; redirect_pc = 16'h0123; mem_ack = 1'b1; mem_rdata = 16'hBEEF;
      tick();
      redirect = 1'b0; mem_ack = 1'b0;
      check("coinc_valid", instr_valid, 0);
      check("coinc_req", mem_req, 1);
      check("coinc_addr", mem_addr, 16'h0123);
      check("coinc_instr_kept", Instruction, 16'hABCD);
      check("coinc_bios", is_bios, 1);

      // reach pc 0x0010, then halt with instr_ready
      redirect = 1'b1; redirect_pc = 16'h0010; mem_ack = 1'b1; mem_rdata = 16'h1111;
      tick();
      redirect = 1'b0; mem_rdata = 16'h2222;
      tick();
      mem_ack = 1'b0;
      check("h_instr", Instruction, 16'h2222);
      check("h_pc", pc, 16'h0010);
      halt = 1'b1; instr_ready = 1'b1;
      tick();
      check("halted_valid", instr_valid, 0);
      // halt/instr_ready/mem_ack stay asserted in HALTED and must be ignored
      mem_ack = 1'b1; mem_rdata = 16'h9999;
      for (int i = 0; i < 10; i++) begin
         check("halted_req", mem_req, 0);
         check("halted_pc", pc, 16'h0011);
         tick();
      end
      check("halted_instr_kept", Instruction, 16'h2222);
      halt = 1'b0; instr_ready = 1'b0; mem_ack = 1'b0; resume = 1'b1;
      tick();
      resume = 1'b0;
      check("resume_req", mem_req, 1);
      check("resume_addr", mem_addr, 16'h0011);

      // pc 0xFFFF consumed -> wraps to 0
      redirect = 1'b1; redirect_pc = 16'hFFFF; mem_ack = 1'b1; mem_rdata = 16'h4444;
      tick();
      redirect = 1'b0; mem_rdata = 16'h7777;
      tick();
      mem_ack = 1'b0;
      check("top_instr", Instruction, 16'h7777);
      check("top_pc", pc, 16'hFFFF);
      check("top_bios", is_bios, 0);
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      check("wrap_addr", mem_addr, 16'h0000);
      check("wrap_req", mem_req, 1);
      check("wrap_bios", is_bios, 1);

      // redirect in HOLD beats instr_ready: no pc+1, no count
      mem_ack = 1'b1; mem_rdata = 16'h3333;
      tick();
      mem_ack = 1'b0;
      check("rh_valid", instr_valid, 1);
      redirect = 1'b1; redirect_pc = 16'h0200; instr_ready = 1'b1;
      tick();
      redirect = 1'b0; instr_ready = 1'b0;
      check("rh_valid_clr", instr_valid, 0);
      check("rh_addr", mem_addr, 16'h0200);
      check("rh_req", mem_req, 1);
      check("count_final", fetch_count, PERF ? 5 : 0);

      // reset in the middle of a fetch abandons the request
      reset = 1'b1;
      tick();
      check("mid_rst_req", mem_req, 0);
      check("mid_rst_pc", pc, 0);
      check("mid_rst_instr", Instruction, 16'hFFFF);
      check("mid_rst_count", fetch_count, 0);
      reset = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hDEAD;
      tick();
      mem_ack = 1'b0;
      check("mid_rst_stale", instr_valid, 0);
      check("mid_rst_addr", mem_addr, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
